// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Walk the requesters starting at ptr and wrapping around.
    // Return the first requester that is asserting its request.
    // If nothing is requesting, return ptr; callers only use the
    // result when req is non-zero.
    function automatic logic [1:0] rr_select(input logic [N_REQ-1:0] req,
                                             input logic [1:0]       ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/onehot_dec2.sv
// Combinational 2-bit binary to 4-bit one-hot decoder.
module onehot_dec2
    import arb_pkg::*;
(
    input  logic [1:0]       idx,
    output logic [N_REQ-1:0] onehot
);

    // Shift a single set bit into the position named by idx.
    always_comb begin
        onehot = 4'b0001 << idx;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold-limit timer.
// The grant is released when its owner drops the request. It is also
// released when the owner has held it for MAX_HOLD cycles while
// someone else is waiting. Every release is followed by one idle cycle.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             busy_q, busy_d;

    logic [1:0]       winner;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] own_mask;
    logic             limit_hit;
    logic             others_waiting;

    assign winner = rr_select(req, ptr_q);

    onehot_dec2 u_dec_win (
        .idx    (winner),
        .onehot (win_onehot)
    );

    onehot_dec2 u_dec_own (
        .idx    (gnt_idx_q),
        .onehot (own_mask)
    );

    // Work out the next arbitration state, pointer, hold count and grant.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        gnt_d          = gnt_q;
        gnt_idx_d      = gnt_idx_q;
        busy_d         = busy_q;
        limit_hit      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
        others_waiting = |(req & ~own_mask);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d  = winner;
                    gnt_d      = win_onehot;
                    hold_cnt_d = CNT_ONE;
                    state_d    = GRANT;
                    busy_d     = 1'b1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q] || (limit_hit && others_waiting)) begin
                    gnt_d      = '0;
                    ptr_d      = gnt_idx_q + 2'd1;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                end else if (limit_hit) begin
                    hold_cnt_d = CNT_ONE;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Register the FSM state and every output so downstream sees clean enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4.
// Two instances are tested: one with MAX_HOLD=8 and one with unlimited hold.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, req1, gnt0, gnt1;
    logic [1:0] idx0, idx1;
    logic       v0, v1, b0, b1;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state per DUT: current owner (-1 = none), next
    // priority pointer, cycles held, and the last index that was granted.
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];
    int m_last[2];
    int hold_lim[2] = '{8, 0};

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut_h8 (
        .clk(clk), .rst(rst), .req(req0), .gnt(gnt0),
        .gnt_idx(idx0), .gnt_valid(v0), .busy(b0)
    );

    rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) dut_h0 (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
        .gnt_idx(idx1), .gnt_valid(v1), .busy(b1)
    );

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_held[d]  = 0;
            m_last[d]  = 0;
        end
    endfunction

    // Advance the model by one clock edge with request vector r.
    // Return the outputs expected after that edge.
    function automatic exp_t modelStep(int d, logic [3:0] r);
        exp_t e;
        bit   others;
        bit   limit;
        if (m_owner[d] < 0) begin
            for (int k = 0; k < 4; k++) begin
                int i = (m_ptr[d] + k) % 4;
                if (m_owner[d] < 0 && r[i]) begin
                    m_owner[d] = i;
                    m_held[d]  = 1;
                    m_last[d]  = i;
                end
            end
        end else begin
            others = (r & ~(4'b0001 << m_owner[d])) != 4'b0000;
            limit  = hold_lim[d] != 0 && m_held[d] >= hold_lim[d];
            if (!r[m_owner[d]] || (limit && others)) begin
                m_ptr[d]   = (m_owner[d] + 1) % 4;
                m_owner[d] = -1;
                m_held[d]  = 0;
            end else if (limit) begin
                m_held[d] = 1;
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end
        e.gnt   = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
        e.idx   = 2'(m_last[d]);
        e.valid = m_owner[d] >= 0;
        e.busy  = m_owner[d] >= 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive both request vectors before the next rising edge.
    // Queue up what each DUT should show after that edge.
    task automatic applyStimulus(input logic [3:0] r0, input logic [3:0] r1);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        sb0.push_back(modelStep(0, r0));
        sb1.push_back(modelStep(1, r1));
    endtask

    // Assert reset in the middle of a cycle. Outputs must clear before
    // the next edge arrives.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst  = 1'b1;
        req0 = 4'b0000;
        req1 = 4'b0000;
        #1;
        checkOutput("rst_gnt0", gnt0, 0);
        checkOutput("rst_busy0", b0, 0);
        checkOutput("rst_valid0", v0, 0);
        checkOutput("rst_idx0", idx0, 0);
        checkOutput("rst_gnt1", gnt1, 0);
        checkOutput("rst_busy1", b1, 0);
        checkOutput("rst_valid1", v1, 0);
        checkOutput("rst_idx1", idx1, 0);
        sb0.delete();
        sb1.delete();
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor for the MAX_HOLD=8 instance. Pop an expectation after each edge.
    always @(posedge clk) begin : mon0
        exp_t e;
        #1;
        if (!rst && sb0.size() > 0) begin
            e = sb0.pop_front();
            checkOutput("h8_gnt", gnt0, e.gnt);
            checkOutput("h8_idx", idx0, e.idx);
            checkOutput("h8_valid", v0, e.valid);
            checkOutput("h8_busy", b0, e.busy);
        end
    end

    // Monitor for the unlimited-hold instance.
    always @(posedge clk) begin : mon1
        exp_t e;
        #1;
        if (!rst && sb1.size() > 0) begin
            e = sb1.pop_front();
            checkOutput("h0_gnt", gnt1, e.gnt);
            checkOutput("h0_idx", idx1, e.idx);
            checkOutput("h0_valid", v1, e.valid);
            checkOutput("h0_busy", b1, e.busy);
        end
    end

    // Guard against a hung run.
    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] r0, r1;
        logic [3:0] mask;
        rst  = 1'b1;
        req0 = 4'b0000;
        req1 = 4'b0000;
        modelReset();
        doReset();

        // Build up a grant on both instances, then reset in the middle of it.
        repeat (4) applyStimulus(4'b1111, 4'b1111);
        doReset();
        applyStimulus(4'b1111, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // H8 instance: requesters 0 and 1 both hold their requests, so the
        // hold limit forces preemption.
        // H0 instance: all four request. Each owner drops its request after
        // holding the grant for two cycles.
        for (int c = 0; c < 40; c++) begin
            r1 = 4'b1111;
            if (m_owner[1] >= 0 && m_held[1] >= 2) r1 = 4'b1111 & ~(4'b0001 << m_owner[1]);
            applyStimulus(4'b0011, r1);
        end
        applyStimulus(4'b0000, 4'b0000);

        // A single requester with no contention keeps its grant continuously.
        for (int c = 0; c < 20; c++) applyStimulus(4'b0001, 4'($urandom_range(0, 15)));
        applyStimulus(4'b0000, 4'b0000);

        // Single requester 2, then check that priority wraps from 3 back to 0.
        applyStimulus(4'b0100, 4'b0000);
        applyStimulus(4'b0100, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b1001, 4'b0000);
        applyStimulus(4'b1001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Random traffic: each request bit toggles with probability 1/4 per cycle.
        r0 = 4'b0000;
        r1 = 4'b0000;
        for (int c = 0; c < 300; c++) begin
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 3) == 0);
            r0 = r0 ^ mask;
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 3) == 0);
            r1 = r1 ^ mask;
            applyStimulus(r0, r1);
        end

        repeat (2) @(negedge clk);
        checkOutput("drain_h8", sb0.size(), 0);
        checkOutput("drain_h0", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
